ascii_sym_stream_decoder: RTL
=============================

ASCII_SYM_STREAM_DECODER -- requirements
Module: ascii_sym_stream_decoder

Interface
REQ-001 Parameter FIFO_DEPTH, default 8: output symbol FIFO entries; power of two, 2..64.
REQ-002 Parameter EXT_OPS, default 0: 1 = also decode '*' (8'h2A) and '/' (8'h2F).
REQ-003 Parameter DROP_INVALID, default 1: 1 = discard unmapped chars; 0 = enqueue `DAU_SYM_INVALID.
REQ-004 Parameter ERR_CNT_WIDTH, default 8: invalid-character counter width.
REQ-005 i_clk  input  1  single clock, all state on rising edge.
REQ-006 i_rst_n  input  1  asynchronous, active-low reset.
REQ-007 i_clear  input  1  synchronous flush of FIFO, counter and CR flag.
REQ-008 i_char  input  8  ASCII byte.
REQ-009 i_valid  input  1  i_char valid.
REQ-010 o_ready  output  1  decoder can accept i_char this cycle.
REQ-011 o_symbol  output  `DAU_SYM_WIDTH  head-of-FIFO symbol (from dau_symbols.vh).
REQ-012 o_valid  output  1  o_symbol valid.
REQ-013 i_ready  input  1  consumer takes o_symbol.
REQ-014 o_count  output  $clog2(FIFO_DEPTH)+1  FIFO occupancy.
REQ-015 o_err_cnt  output  ERR_CNT_WIDTH  saturating count of invalid chars accepted.

Function
REQ-016 Input accepted when i_valid && o_ready; o_ready = !(FIFO full) && !i_clear, combinational.
REQ-017 Mapping: 8'h0D -> 5'h0D (Enter); 8'h30..8'h39 -> {1'b1,char[3:0]} (5'h10..5'h19); 8'h2B..8'h2D -> {1'b1,char[3:0]} (5'h1B..5'h1D).
REQ-018 With EXT_OPS=1 additionally 8'h2A -> 5'h1A, 8'h2F -> 5'h1F; 8'h2E stays invalid; with EXT_OPS=0 both invalid.
REQ-019 Every other byte is invalid: o_err_cnt increments by 1, saturating at all-ones, never wraps.
REQ-020 Invalid byte with DROP_INVALID=1 is consumed, nothing enqueued; DROP_INVALID=0 enqueues `DAU_SYM_INVALID.
REQ-021 Latency: symbol of a char accepted in cycle N is visible with o_valid=1 in cycle N+1 if FIFO was empty; FIFO order preserved.
REQ-022 Pop when o_valid && i_ready; o_symbol/o_valid change only after a pop or into an empty FIFO.
REQ-023 Simultaneous push and pop: both take effect, o_count unchanged; when empty, push occurs and pop does not.
REQ-024 Full (o_count=FIFO_DEPTH): o_ready=0; a pop in that cycle frees space only for the next cycle.
REQ-025 Read/write pointers wrap modulo FIFO_DEPTH with no lost or duplicated entries.
REQ-026 i_clear=1: next edge empties FIFO, o_err_cnt=0, CR flag=0; concurrent input is not accepted, pop ignored.
REQ-027 o_symbol is 0 whenever o_valid=0.

Reset
REQ-028 i_rst_n low asynchronously forces: FIFO empty, o_valid=0, o_symbol=0, o_count=0, o_err_cnt=0, CR flag=0.
REQ-029 During reset o_ready=1; first acceptance possible on the first rising edge after i_rst_n rises.
REQ-030 Reset mid-stream discards all buffered symbols; no partial symbol appears after release.

Configuration
REQ-031 Macro ASCII_SYM_CRLF_EN defined: 8'h0A maps to Enter 5'h0D, except an LF accepted as the next char after an accepted CR is consumed silently (not enqueued, not counted); CR flag set by CR, cleared by any other accepted char.
REQ-032 Macro undefined: 8'h0A is invalid per REQ-019/020 and no CR flag exists.

Verification
REQ-033 Stream "12+3\r" (31,32,2B,33,0D), i_ready=1 -> symbols 11,12,1B,13,0D in order, each one cycle after acceptance, o_err_cnt=0.
REQ-034 i_ready=0, push 9 digits with FIFO_DEPTH=8 -> o_ready=0 after 8th, o_count=8; one pop -> o_ready=1 next cycle, 9th char accepted.
REQ-035 DROP_INVALID=1, bytes 41,2E,35 -> only 15 emitted, o_err_cnt=2; DROP_INVALID=0 -> INVALID,INVALID,15 emitted.
REQ-036 ERR_CNT_WIDTH=2, five invalid bytes -> o_err_cnt holds 3.
REQ-037 ASCII_SYM_CRLF_EN: 0D,0A,0A -> symbols 0D,0D, o_err_cnt=0; without macro -> 0D only, o_err_cnt=2.
REQ-038 i_rst_n pulsed low with 5 entries queued -> o_valid=0, o_count=0 immediately; i_clear with 3 queued -> o_count=0 next cycle.

Source files
------------

// File: rtl/ascii_sym_stream_decoder.sv
// ASCII byte stream to calculator-key symbol decoder with an output FIFO.
// Optional CR/LF folding is enabled with `define ASCII_SYM_CRLF_EN.
`ifndef DAU_SYM_WIDTH
`define DAU_SYM_WIDTH 5
`endif
`ifndef DAU_SYM_INVALID
`define DAU_SYM_INVALID 5'h1E
`endif

module ascii_sym_stream_decoder #(
  parameter int FIFO_DEPTH    = 8,
  parameter int EXT_OPS       = 0,
  parameter int DROP_INVALID  = 1,
  parameter int ERR_CNT_WIDTH = 8
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic                          i_clear,
  input  logic [7:0]                    i_char,
  input  logic                          i_valid,
  output logic                          o_ready,
  output logic [`DAU_SYM_WIDTH-1:0]     o_symbol,
  output logic                          o_valid,
  input  logic                          i_ready,
  output logic [$clog2(FIFO_DEPTH):0]   o_count,
  output logic [ERR_CNT_WIDTH-1:0]      o_err_cnt
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = `DAU_SYM_WIDTH;

  logic [SW-1:0]            mem_q [FIFO_DEPTH];
  logic [AW-1:0]            wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic [ERR_CNT_WIDTH-1:0] err_q;

  logic          map_ok, lf_skip, accept, push, pop, bad;
  logic [SW-1:0] map_sym, push_sym;

  // Digits and operators share the encoding {1, low nibble of the ASCII code}.
  always_comb begin
    map_ok  = 1'b0;
    map_sym = '0;
    if (i_char == 8'h0D) begin
      map_ok  = 1'b1;
      map_sym = SW'(5'h0D);
    end else if ((i_char[7:4] == 4'h3 && i_char[3:0] <= 4'h9) ||
                 (i_char >= 8'h2B && i_char <= 8'h2D) ||
                 (EXT_OPS != 0 && (i_char == 8'h2A || i_char == 8'h2F))) begin
      map_ok  = 1'b1;
      map_sym = SW'({1'b1, i_char[3:0]});
    end
`ifdef ASCII_SYM_CRLF_EN
    else if (i_char == 8'h0A) begin
      map_ok  = 1'b1;
      map_sym = SW'(5'h0D);
    end
`endif
  end

`ifdef ASCII_SYM_CRLF_EN
  logic cr_q;
  // An LF directly after a CR is the tail of a CRLF pair and carries no key.
  assign lf_skip = cr_q && (i_char == 8'h0A);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)     cr_q <= 1'b0;
    else if (i_clear) cr_q <= 1'b0;
    else if (accept)  cr_q <= (i_char == 8'h0D);
  end
`else
  assign lf_skip = 1'b0;
`endif

  assign o_valid  = (cnt_q != '0);
  assign o_ready  = (cnt_q != CW'(FIFO_DEPTH)) && !i_clear;
  assign accept   = i_valid && o_ready;
  assign pop      = o_valid && i_ready && !i_clear;
  assign bad      = accept && !lf_skip && !map_ok;
  assign push     = accept && !lf_skip && (map_ok || DROP_INVALID == 0);
  assign push_sym = map_ok ? map_sym : SW'(`DAU_SYM_INVALID);
  assign o_symbol = o_valid ? mem_q[rd_ptr_q] : '0;
  assign o_count  = cnt_q;
  assign o_err_cnt = err_q;

  always_comb begin
    cnt_d = cnt_q;
    if (push && !pop)      cnt_d = cnt_q + CW'(1);
    else if (pop && !push) cnt_d = cnt_q - CW'(1);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      err_q    <= '0;
    end else if (i_clear) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      err_q    <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      if (bad && err_q != '1) err_q <= err_q + ERR_CNT_WIDTH'(1);
    end
  end

  // Storage needs no reset: o_symbol is masked while the FIFO is empty.
  always_ff @(posedge i_clk) begin
    if (push) mem_q[wr_ptr_q] <= push_sym;
  end
endmodule
